// File: rtl/btb_predictor.sv
// Direct-mapped branch target buffer with 2-bit direction counters.
// Ports:
//   clk, reset            - clock, asynchronous active-high reset
//   PCF                   - fetch PC to look up (combinational lookup)
//   predPCF, predTakenF   - predicted next fetch PC and taken flag
//   updateE, PCE, takenE, targetE - resolved control-flow from execute
//   flushBTB              - invalidate all entries at the next edge
//   hitCount              - saturating count of correct taken predictions
module btb_predictor #(
    parameter int unsigned XLEN    = 64,
    parameter int unsigned ENTRIES = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [XLEN-1:0] PCF,
    output logic [XLEN-1:0] predPCF,
    output logic            predTakenF,
    input  logic            updateE,
    input  logic [XLEN-1:0] PCE,
    input  logic            takenE,
    input  logic [XLEN-1:0] targetE,
    input  logic            flushBTB,
    output logic [15:0]     hitCount
);

    localparam int unsigned IDX  = $clog2(ENTRIES);
    localparam int unsigned TAGW = XLEN - IDX - 2;

    logic [ENTRIES-1:0] valid;
    logic [1:0]         ctr    [ENTRIES];
    logic [TAGW-1:0]    tag    [ENTRIES];
    logic [XLEN-1:0]    target [ENTRIES];

    logic [IDX-1:0]  f_idx;
    logic [TAGW-1:0] f_tag;
    logic            f_hit;
    logic [IDX-1:0]  e_idx;
    logic [TAGW-1:0] e_tag;
    logic            e_hit;
    logic            e_correct;
    logic            unused_pc_lsbs;

    // Instructions are word aligned; the two low PC bits carry no index/tag info.
    assign unused_pc_lsbs = ^{PCF[1:0], PCE[1:0]};

    // Fetch-side lookup, combinational from current table state.
    assign f_idx      = PCF[IDX+1:2];
    assign f_tag      = PCF[XLEN-1:IDX+2];
    assign f_hit      = valid[f_idx] && (tag[f_idx] == f_tag);
    assign predTakenF = f_hit && ctr[f_idx][1];
    assign predPCF    = predTakenF ? target[f_idx] : PCF + XLEN'(4);

    // Execute-side lookup against pre-update state.
    assign e_idx     = PCE[IDX+1:2];
    assign e_tag     = PCE[XLEN-1:IDX+2];
    assign e_hit     = valid[e_idx] && (tag[e_idx] == e_tag);
    assign e_correct = e_hit && ctr[e_idx][1] && takenE && (target[e_idx] == targetE);

    // Valid bits, direction counters and hit counter; flush overrides any update.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid    <= '0;
            hitCount <= 16'd0;
            for (int i = 0; i < int'(ENTRIES); i++) begin
                ctr[i] <= 2'b01;
            end
        end else if (flushBTB) begin
            valid <= '0;
        end else if (updateE) begin
            if (e_hit) begin
                if (takenE && ctr[e_idx] != 2'b11) begin
                    ctr[e_idx] <= ctr[e_idx] + 2'd1;
                end else if (!takenE && ctr[e_idx] != 2'b00) begin
                    ctr[e_idx] <= ctr[e_idx] - 2'd1;
                end
            end else if (takenE) begin
                valid[e_idx] <= 1'b1;
                ctr[e_idx]   <= 2'b10;
            end
            if (e_correct && hitCount != 16'hFFFF) begin
                hitCount <= hitCount + 16'd1;
            end
        end
    end

    // Tag/target payload is not reset; gating on reset drops an in-flight update.
    // A taken hit rewrites the same tag, so hit and allocate share one write.
    always_ff @(posedge clk) begin
        if (!reset && !flushBTB && updateE && takenE) begin
            tag[e_idx]    <= e_tag;
            target[e_idx] <= targetE;
        end
    end

endmodule

// File: tb/tb_btb_predictor.sv
// Randomized and directed bench for btb_predictor with a behavioural table model.
module tb_btb_predictor;

    localparam int unsigned XLEN    = 64;
    localparam int unsigned ENTRIES = 16;
    localparam int unsigned IDX     = $clog2(ENTRIES);

    logic            clk = 1'b0;
    logic            reset;
    logic [XLEN-1:0] PCF, PCE, targetE;
    logic [XLEN-1:0] predPCF;
    logic            predTakenF;
    logic            updateE, takenE, flushBTB;
    logic [15:0]     hitCount;

    int errors = 0;
    int checks = 0;

    // Reference model state
    bit              m_valid  [ENTRIES];
    logic [XLEN-1:0] m_tag    [ENTRIES];
    logic [XLEN-1:0] m_target [ENTRIES];
    int              m_ctr    [ENTRIES];
    int              m_hits;

    logic [XLEN-1:0] obs_pc;
    logic            obs_taken;

    btb_predictor #(.XLEN(XLEN), .ENTRIES(ENTRIES)) dut (
        .clk        (clk),
        .reset      (reset),
        .PCF        (PCF),
        .predPCF    (predPCF),
        .predTakenF (predTakenF),
        .updateE    (updateE),
        .PCE        (PCE),
        .takenE     (takenE),
        .targetE    (targetE),
        .flushBTB   (flushBTB),
        .hitCount   (hitCount)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic int unsigned idx_of(input logic [XLEN-1:0] pc);
        return int'((pc / 4) % ENTRIES);
    endfunction

    function automatic logic [XLEN-1:0] tag_of(input logic [XLEN-1:0] pc);
        return pc / (4 * ENTRIES);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < int'(ENTRIES); i++) begin
            m_valid[i] = 1'b0;
            m_ctr[i]   = 1;
        end
        m_hits = 0;
    endtask

    // One clock: drive inputs, check lookup vs model, clock, update model, check hitCount.
    task automatic cycle(input logic [XLEN-1:0] pcf, input logic upd, input logic [XLEN-1:0] pce,
                         input logic tk, input logic [XLEN-1:0] tgt, input logic fl);
        int unsigned i;
        bit hit, exp_tk;
        logic [XLEN-1:0] exp_pc;
        PCF = pcf; updateE = upd; PCE = pce; takenE = tk; targetE = tgt; flushBTB = fl;
        #1;
        i      = idx_of(pcf);
        hit    = m_valid[i] && (m_tag[i] == tag_of(pcf));
        exp_tk = hit && (m_ctr[i] >= 2);
        exp_pc = exp_tk ? m_target[i] : pcf + 64'd4;
        obs_pc = predPCF; obs_taken = predTakenF;
        check("pred_taken", 64'(predTakenF), 64'(exp_tk));
        check("pred_pc", predPCF, exp_pc);
        @(posedge clk);
        if (fl) begin
            for (int k = 0; k < int'(ENTRIES); k++) m_valid[k] = 1'b0;
        end else if (upd) begin
            i   = idx_of(pce);
            hit = m_valid[i] && (m_tag[i] == tag_of(pce));
            if (hit && m_ctr[i] >= 2 && tk && m_target[i] == tgt && m_hits < 65535) m_hits++;
            if (hit) begin
                m_ctr[i] = tk ? ((m_ctr[i] < 3) ? m_ctr[i] + 1 : 3) : ((m_ctr[i] > 0) ? m_ctr[i] - 1 : 0);
                if (tk) m_target[i] = tgt;
            end else if (tk) begin
                m_valid[i] = 1'b1; m_tag[i] = tag_of(pce); m_target[i] = tgt; m_ctr[i] = 2;
            end
        end
        @(negedge clk);
        check("hit_count", 64'(hitCount), 64'(m_hits));
    endtask

    task automatic idle(input logic [XLEN-1:0] pcf);
        cycle(pcf, 1'b0, '0, 1'b0, '0, 1'b0);
    endtask

    initial begin
        logic [XLEN-1:0] pc_a, pc_b, tg;
        reset = 1'b1; PCF = 64'h1000; PCE = '0; targetE = '0;
        updateE = 1'b0; takenE = 1'b0; flushBTB = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        check("rst_taken", 64'(predTakenF), 64'd0);
        check("rst_pc", predPCF, 64'h1004);
        check("rst_hits", 64'(hitCount), 64'd0);
        reset = 1'b0;

        idle(64'h1000);
        check("cold_pc", obs_pc, 64'h1004);
        // Allocate, then predict taken
        cycle(64'h1000, 1'b1, 64'h1000, 1'b1, 64'h2000, 1'b0);
        idle(64'h1000);
        check("alloc_taken", 64'(obs_taken), 64'd1);
        check("alloc_pc", obs_pc, 64'h2000);
        // Two not-taken: 10->01->00, then saturate at 00
        cycle(64'h1000, 1'b1, 64'h1000, 1'b0, 64'h0, 1'b0);
        idle(64'h1000);
        check("weak_pc", obs_pc, 64'h1004);
        cycle(64'h1000, 1'b1, 64'h1000, 1'b0, 64'h0, 1'b0);
        cycle(64'h1000, 1'b1, 64'h1000, 1'b0, 64'h0, 1'b0);
        // Still valid at 00: two taken needed to predict again
        cycle(64'h1000, 1'b1, 64'h1000, 1'b1, 64'h2000, 1'b0);
        idle(64'h1000);
        check("sat00_pc", obs_pc, 64'h1004);
        cycle(64'h1000, 1'b1, 64'h1000, 1'b1, 64'h2000, 1'b0);
        idle(64'h1000);
        check("recover_pc", obs_pc, 64'h2000);
        // Alias replacement at the same index
        cycle(64'h1000, 1'b1, 64'h1040, 1'b1, 64'h7000, 1'b0);
        idle(64'h1000);
        check("alias_old_pc", obs_pc, 64'h1004);
        idle(64'h1040);
        check("alias_new_pc", obs_pc, 64'h7000);
        // Same-cycle update and lookup
        cycle(64'h3000, 1'b1, 64'h3000, 1'b1, 64'h3800, 1'b0);
        check("same_cyc_pc", obs_pc, 64'h3004);
        idle(64'h3000);
        check("next_cyc_pc", obs_pc, 64'h3800);
        // Three correct taken resolutions, then flush with a taken update
        cycle(64'h6000, 1'b1, 64'h6000, 1'b1, 64'h6100, 1'b0);
        repeat (3) cycle(64'h6000, 1'b1, 64'h6000, 1'b1, 64'h6100, 1'b0);
        check("three_hits", 64'(hitCount), 64'd3);
        cycle(64'h6000, 1'b1, 64'h6000, 1'b1, 64'h6100, 1'b1);
        check("flush_hits", 64'(hitCount), 64'd3);
        idle(64'h6000);
        check("flush_pc", obs_pc, 64'h6004);
        idle(64'h3000);
        check("flush_pc2", obs_pc, 64'h3004);

        // Reset arriving during an update discards it
        PCF = 64'h5000; updateE = 1'b1; PCE = 64'h5000; takenE = 1'b1; targetE = 64'h5500;
        #2 reset = 1'b1;
        #1 check("midrst_taken", 64'(predTakenF), 64'd0);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        idle(64'h5000);
        check("midrst_pc", obs_pc, 64'h5004);
        check("midrst_hits", 64'(hitCount), 64'd0);

        // Randomized traffic over a small PC/target pool so entries alias and hit
        for (int n = 0; n < 600; n++) begin
            pc_a = 64'h8000 + 64'($urandom_range(0, 3)) * 64'h40 + 64'($urandom_range(0, 15)) * 64'd4;
            pc_b = ($urandom_range(0, 3) == 0) ? pc_a
                 : 64'h8000 + 64'($urandom_range(0, 3)) * 64'h40 + 64'($urandom_range(0, 15)) * 64'd4;
            tg   = 64'h9000 + 64'($urandom_range(0, 2)) * 64'h10;
            cycle(pc_a, 1'($urandom_range(0, 9) < 7), pc_b, 1'($urandom_range(0, 9) < 6), tg,
                  1'($urandom_range(0, 99) < 3));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
